// File: rtl/bird_physics.sv
`default_nettype none
// ============================================================================
// Module   : bird_physics
// Purpose  : Per-tick vertical motion for the player sprite: gravity or flap
//            applied to velocity, clamped position, ground-collision detection.
// Revision : 1.0 - initial release
// ============================================================================
module bird_physics #(
    parameter int Y_W     = 10,
    parameter int V_W     = 6,
    parameter int Y_START = 240,
    parameter int Y_MAX   = 464,
    parameter int GRAVITY = 1,
    parameter int FLAP_V  = -8,
    parameter int V_MAX   = 7
) (
    input  logic           iClk,
    input  logic           iRst,
    input  logic           iTick,
    input  logic           iFlap,
    input  logic           iStart,
    output logic [Y_W-1:0] oY,
    output logic [V_W-1:0] oVel,
    output logic           oPlaying,
    output logic           oDead,
    output logic           oUpdate
);

    localparam int SW = Y_W + 1;

    localparam logic signed [SW-1:0] c_GRAV   = SW'(GRAVITY);
    localparam logic signed [SW-1:0] c_FLAP   = SW'(FLAP_V);
    localparam logic signed [SW-1:0] c_VMAX   = SW'(V_MAX);
    localparam logic signed [SW-1:0] c_YMAX_S = SW'(Y_MAX);
    localparam logic [Y_W-1:0]       c_YMAX   = Y_W'(Y_MAX);
    localparam logic [Y_W-1:0]       c_YSTART = Y_W'(Y_START);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    state_t          r_state, w_state_nx;
    logic [Y_W-1:0]  r_y, w_y_nx;
    logic [V_W-1:0]  r_vel, w_vel_nx;
    logic            r_pend, w_pend_nx;
    logic            r_flap_d;
    logic            r_upd, w_upd_nx;

    logic                  w_flap_edge;
    logic signed [SW-1:0]  w_vel_ext;
    logic signed [SW-1:0]  w_vinc;
    logic signed [SW-1:0]  w_vnew;
    logic signed [SW-1:0]  w_ynext;

    assign w_flap_edge = iFlap & ~r_flap_d;

    // A flap edge coincident with the tick counts for that same step.
    assign w_vel_ext = {{(SW-V_W){r_vel[V_W-1]}}, r_vel};
    assign w_vinc    = w_vel_ext + c_GRAV;
    assign w_vnew    = (r_pend | w_flap_edge) ? c_FLAP :
                       ((w_vinc > c_VMAX) ? c_VMAX : w_vinc);
    assign w_ynext   = $signed({1'b0, r_y}) + w_vnew;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state  <= S_IDLE;
            r_y      <= c_YSTART;
            r_vel    <= '0;
            r_pend   <= 1'b0;
            r_flap_d <= 1'b0;
            r_upd    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_y      <= w_y_nx;
            r_vel    <= w_vel_nx;
            r_pend   <= w_pend_nx;
            r_flap_d <= iFlap;
            r_upd    <= w_upd_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_y_nx     = r_y;
        w_vel_nx   = r_vel;
        w_pend_nx  = r_pend;
        w_upd_nx   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The edge that starts play is not also taken as a flap.
                if (iStart || w_flap_edge) begin
                    w_state_nx = S_PLAY;
                    w_vel_nx   = '0;
                    w_pend_nx  = 1'b0;
                end
            end
            S_PLAY: begin
                if (iTick) begin
                    w_upd_nx  = 1'b1;
                    w_pend_nx = 1'b0;
                    if (w_ynext[SW-1]) begin
                        w_y_nx   = '0;
                        w_vel_nx = '0;
                    end else if (w_ynext >= c_YMAX_S) begin
                        w_y_nx     = c_YMAX;
                        w_vel_nx   = '0;
                        w_state_nx = S_DEAD;
                    end else begin
                        w_y_nx   = w_ynext[Y_W-1:0];
                        w_vel_nx = w_vnew[V_W-1:0];
                    end
                end else if (w_flap_edge) begin
                    w_pend_nx = 1'b1;
                end
            end
            S_DEAD: begin
                if (iStart) begin
                    w_state_nx = S_IDLE;
                    w_y_nx     = c_YSTART;
                    w_vel_nx   = '0;
                    w_pend_nx  = 1'b0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    assign oY       = r_y;
    assign oVel     = r_vel;
    assign oPlaying = (r_state == S_PLAY);
    assign oDead    = (r_state == S_DEAD);
    assign oUpdate  = r_upd;

endmodule
`default_nettype wire

// File: tb/tb_bird_physics.sv
`default_nettype none
// ============================================================================
// Module   : tb_bird_physics
// Purpose  : Self-checking bench for bird_physics against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bird_physics;

    logic       iClk = 1'b0;
    logic       iRst = 1'b0;
    logic       iTick = 1'b0;
    logic       iFlap = 1'b0;
    logic       iStart = 1'b0;
    logic [9:0] oY;
    logic [5:0] oVel;
    logic       oPlaying;
    logic       oDead;
    logic       oUpdate;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: plain integers, mode 0=idle 1=play 2=dead
    int m_mode = 0;
    int m_y    = 240;
    int m_v    = 0;
    int m_pend = 0;
    int m_prev = 0;
    int m_upd  = 0;

    bird_physics dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iTick    (iTick),
        .iFlap    (iFlap),
        .iStart   (iStart),
        .oY       (oY),
        .oVel     (oVel),
        .oPlaying (oPlaying),
        .oDead    (oDead),
        .oUpdate  (oUpdate)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int rst, input int tick, input int flap, input int start);
        int edge_f;
        int vnew;
        int yn;
        edge_f = (flap != 0 && m_prev == 0) ? 1 : 0;
        if (rst != 0) begin
            m_mode = 0; m_y = 240; m_v = 0; m_pend = 0; m_prev = 0; m_upd = 0;
            return;
        end
        m_upd = 0;
        if (m_mode == 0) begin
            if (start != 0 || edge_f != 0) begin
                m_mode = 1; m_v = 0; m_pend = 0;
            end
        end else if (m_mode == 1) begin
            if (tick != 0) begin
                if (m_pend != 0 || edge_f != 0) vnew = -8;
                else vnew = (m_v + 1 > 7) ? 7 : m_v + 1;
                yn = m_y + vnew;
                m_upd = 1;
                m_pend = 0;
                if (yn < 0) begin
                    m_y = 0; m_v = 0;
                end else if (yn >= 464) begin
                    m_y = 464; m_v = 0; m_mode = 2;
                end else begin
                    m_y = yn; m_v = vnew;
                end
            end else if (edge_f != 0) begin
                m_pend = 1;
            end
        end else begin
            if (start != 0) begin
                m_mode = 0; m_y = 240; m_v = 0; m_pend = 0;
            end
        end
        m_prev = flap;
    endtask

    task automatic check_all(input string where);
        logic [9:0] ey;
        logic [5:0] ev;
        ey = m_y[9:0];
        ev = m_v[5:0];
        chk({where, ".oY"}, 32'(oY), 32'(ey));
        chk({where, ".oVel"}, 32'(oVel), 32'(ev));
        chk({where, ".oPlaying"}, 32'(oPlaying), (m_mode == 1) ? 32'd1 : 32'd0);
        chk({where, ".oDead"}, 32'(oDead), (m_mode == 2) ? 32'd1 : 32'd0);
        chk({where, ".oUpdate"}, 32'(oUpdate), 32'(m_upd));
    endtask

    // Drive one cycle of inputs, advance the model on the edge, check after it.
    task automatic step(input int rst, input int tick, input int flap, input int start,
                        input string where);
        iRst   = (rst != 0);
        iTick  = (tick != 0);
        iFlap  = (flap != 0);
        iStart = (start != 0);
        @(posedge iClk);
        model_step(rst, tick, flap, start);
        #1;
        check_all(where);
    endtask

    initial begin
        int k;
        int flap_lvl;

        // Reset
        step(1, 0, 0, 0, "rst0");
        step(1, 0, 0, 0, "rst1");
        chk("rst.y240", 32'(oY), 32'd240);
        chk("rst.vel0", 32'(oVel), 32'd0);

        // Free fall: 241, 243, 246
        step(0, 0, 0, 1, "start");
        chk("start.playing", 32'(oPlaying), 32'd1);
        step(0, 1, 0, 0, "ff1");
        chk("ff1.y", 32'(oY), 32'd241);
        step(0, 0, 0, 0, "ff_gap");
        chk("ff_gap.upd", 32'(oUpdate), 32'd0);
        step(0, 1, 0, 0, "ff2");
        chk("ff2.y", 32'(oY), 32'd243);
        step(0, 1, 0, 0, "ff3");
        chk("ff3.y", 32'(oY), 32'd246);
        chk("ff3.vel", 32'(oVel), 32'd3);

        // Flap coincident with tick, then held flap over two ticks
        step(0, 1, 1, 0, "flap_tick");
        chk("flap_tick.y", 32'(oY), 32'd238);
        chk("flap_tick.vel", 32'(oVel), 32'h38);
        step(0, 0, 1, 0, "hold_gap");
        step(0, 1, 1, 0, "hold1");
        chk("hold1.vel", 32'(oVel), 32'h39);
        step(0, 1, 1, 0, "hold2");
        chk("hold2.vel", 32'(oVel), 32'h3a);
        step(0, 0, 0, 0, "rel");

        // Edge one cycle after a tick waits for the next step
        step(0, 1, 0, 0, "pre_tick");
        step(0, 0, 1, 0, "late_edge");
        step(0, 0, 0, 0, "late_wait");
        step(0, 1, 0, 0, "late_step");
        chk("late_step.vel", 32'(oVel), 32'h38);

        // Terminal velocity
        step(1, 0, 0, 0, "rst_tv");
        step(0, 0, 0, 1, "start_tv");
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0, "tv");
            if (i == 6) chk("tv7.y", 32'(oY), 32'd268);
        end
        chk("tv.vel", 32'(oVel), 32'd7);

        // Ceiling clamp
        step(1, 0, 0, 0, "rst_ceil");
        step(0, 0, 0, 1, "start_ceil");
        for (int i = 0; i < 31; i++) begin
            step(0, 0, 1, 0, "ceil_edge");
            step(0, 0, 0, 0, "ceil_rel");
            step(0, 1, 0, 0, "ceil_tick");
        end
        chk("ceil.y", 32'(oY), 32'd0);
        chk("ceil.vel", 32'(oVel), 32'd0);
        chk("ceil.dead", 32'(oDead), 32'd0);

        // Ground
        k = 0;
        while (oDead !== 1'b1 && k < 300) begin
            step(0, 1, 0, 0, "fall");
            k++;
        end
        chk("ground.reached", (k < 300) ? 32'd1 : 32'd0, 32'd1);
        chk("ground.y", 32'(oY), 32'd464);
        chk("ground.playing", 32'(oPlaying), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 0, "dead_tick");
            step(0, 0, 0, 0, "dead_rel");
        end
        step(0, 0, 0, 1, "restart");
        chk("restart.y", 32'(oY), 32'd240);
        chk("restart.dead", 32'(oDead), 32'd0);

        // Reset mid-play with coincident tick
        step(0, 0, 0, 1, "start_mr");
        step(0, 1, 0, 0, "mr_t1");
        step(0, 1, 0, 0, "mr_t2");
        step(1, 1, 0, 0, "mr_rst");
        chk("mr.upd", 32'(oUpdate), 32'd0);
        chk("mr.y", 32'(oY), 32'd240);

        // Randomized traffic
        flap_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            int r_tick, r_start, r_rst;
            r_tick  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            r_start = ($urandom_range(0, 40) == 0) ? 1 : 0;
            r_rst   = ($urandom_range(0, 400) == 0) ? 1 : 0;
            if ($urandom_range(0, 5) == 0) flap_lvl = 1 - flap_lvl;
            step(r_rst, r_tick, flap_lvl, r_start, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
